pb_varint_stream_decoder: RTL and testbench
===========================================

Name: pb_varint_stream_decoder

Overview:
Hardware successor to the package-level protobuf varint decode routines. Consumes a byte stream over a valid/ready handshake and emits one decoded varint per transaction. Parametrised in value width and maximum encoded length. Adds a per-varint key mode (field number / wire type split) and error classification. Sits between the message byte-stream ingress and the field dispatch logic.

Parameters:
- VALUE_W, 64: decoded value width; legal range 8..64.
- MAX_BYTES, 10: maximum encoded bytes per varint; must equal ceil(VALUE_W/7).
- NB_W, 4: width of out_nbytes; must be >= $clog2(MAX_BYTES+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte valid
- in_ready  out  1  decoder accepts byte
- in_data  in  8  encoded byte; bit7 is the continuation flag
- in_last  in  1  byte is the last of the enclosing message
- in_key  in  1  sampled on the first byte: 1 = decode as tag key
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_value  out  VALUE_W  decoded value (zigzag-adjusted when enabled)
- out_field  out  29  field number (value>>3) in key mode, else 0
- out_wire  out  3  wire type (value[2:0]) in key mode, else 0
- out_nbytes  out  NB_W  bytes consumed by this varint, including drained bytes
- out_err  out  3  0 none, 1 overlong, 2 truncated, 3 overflow, 4 bad key

Behaviour:
- Reset: state IDLE; out_valid=0; out_value, out_field, out_wire, out_nbytes and out_err = 0; accumulator and byte index cleared. Reset mid-varint discards the partial value; no output.
- Handshake: byte accepted when in_valid&in_ready. in_ready = (state!=HOLD) | out_ready. Result is consumed when out_valid&out_ready.
- Output hold: out_* are held stable while out_valid=1 and out_ready=0.
- FSM states: IDLE, ACCUM, DRAIN, HOLD.
- IDLE: on accept, latch in_key; acc = data[6:0]; idx = 1. If bit7=0, go to HOLD. Otherwise go to ACCUM.
- ACCUM: on accept, acc |= data[6:0] << 7*idx, truncated to VALUE_W; idx++.
  - bit7=0: go to HOLD.
  - bit7=1 and idx reaches MAX_BYTES: go to DRAIN with err=1.
  - bit7=1 and in_last: go to HOLD with err=2 (takes precedence over overlong).
- Overflow: on the final byte, any nonzero payload bit at or above VALUE_W sets err=3; the value is truncated. Example: VALUE_W=64, 10th byte > 0x01.
- DRAIN: accepts and discards bytes, counting them, until a byte with bit7=0 or in_last arrives; then go to HOLD with err=1.
- Latency: out_valid asserts the cycle after the terminating byte is accepted.
- Back-to-back: in HOLD with out_ready=1, the next varint's first byte is accepted in the same cycle, giving one varint per cycle for 1-byte varints.
- Key mode: out_field = acc[31:3]; out_wire = acc[2:0]. err=4 when wire is 6 or 7, or field is 0; this is reported only if no earlier error is set.
- Error priority: 2 > 1 > 3 > 4.
- out_nbytes saturates at 2^NB_W-1.

Optional Feature:
- Macro: PB_VARINT_ZIGZAG_EN.
- Enabled: adds input port in_zigzag (1 bit), sampled on the first byte alongside in_key. When set and in_key=0, out_value = (acc>>1) ^ -(acc&1), i.e. sint32/sint64 decode.
- Disabled: the port is absent and out_value is always the raw accumulated value.
- Added logic is purely combinational at the HOLD register input; latency is unchanged.

Test Plan:
- Bytes 0x96,0x01, in_key=0 -> one cycle later out_value=150, out_nbytes=2, out_err=0.
- Byte 0x08, in_key=1 -> out_field=1, out_wire=0, out_value=8, out_err=0; byte 0x0F, in_key=1 -> out_wire=7, out_err=4.
- 0xFF x9 then 0x01, VALUE_W=64 -> out_value=64'hFFFF_FFFF_FFFF_FFFF, out_nbytes=10; 0xFF x9 then 0x02 -> out_err=3.
- 0x80 x11 then 0x00 -> single output with out_err=1, out_nbytes=12; the next varint 0x05 decodes to 5.
- 0x80 with in_last=1 -> out_err=2, out_nbytes=1.
- 0x01,0x02,0x03 streamed with out_ready held low 3 cycles -> out_value=1 held stable, then 1,2,3 in order with none lost.
- Reset asserted after 0x80 is accepted, then 0x05 -> only out_value=5 is output.
- PB_VARINT_ZIGZAG_EN builds: 0x03 with in_zigzag=1 -> out_value=-2; 0x04 with in_zigzag=1 -> out_value=2.

Source files
------------

// File: rtl/pb_varint_stream_decoder.sv
// Streaming protobuf varint decoder with tag-key split and error classification.
// Optional sint zigzag decode is compiled in with PB_VARINT_ZIGZAG_EN.
module pb_varint_stream_decoder #(
    parameter int VALUE_W   = 64,
    parameter int MAX_BYTES = 10,
    parameter int NB_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    input  logic               in_key,
`ifdef PB_VARINT_ZIGZAG_EN
    input  logic               in_zigzag,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VALUE_W-1:0] out_value,
    output logic [28:0]        out_field,
    output logic [2:0]         out_wire,
    output logic [NB_W-1:0]    out_nbytes,
    output logic [2:0]         out_err
);

    localparam int IDX_W    = $clog2(MAX_BYTES + 1);
    localparam int SH_W     = $clog2(7 * MAX_BYTES + 1);
    localparam int TOP_BITS = VALUE_W - 7 * (MAX_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] acc_q, acc_new;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_W-1:0]    nbytes_q, nbytes_new;
    logic               key_q, key_cur;
    logic               zz_cur;
    logic [VALUE_W-1:0] out_value_q, out_value_d;
    logic [28:0]        out_field_q, out_field_d;
    logic [2:0]         out_wire_q, out_wire_d;
    logic [NB_W-1:0]    out_nbytes_q;
    logic [2:0]         out_err_q, out_err_d;

    logic               accept, first, cont, term, at_last_idx, ovf, key_bad;
    logic [SH_W-1:0]    shamt;
    logic [VALUE_W-1:0] sh_data;
    logic [31:0]        key_word;
    logic [2:0]         err_raw;

    // A byte arriving in HOLD (with the result being taken) starts a new varint.
    assign first       = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign accept      = in_valid && in_ready;
    assign cont        = in_data[7];
    assign at_last_idx = (idx_q == IDX_W'(MAX_BYTES - 1));
    assign ovf         = |(in_data[6:0] >> TOP_BITS);

`ifdef PB_VARINT_ZIGZAG_EN
    logic zz_q;
    assign zz_cur = first ? in_zigzag : zz_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      zz_q <= 1'b0;
        else if (accept) zz_q <= zz_cur;
    end
`else
    assign zz_cur = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept)
                    state_d = (!cont || in_last) ? S_HOLD : S_ACCUM;
                else if (state_q == S_HOLD && out_ready)
                    state_d = S_IDLE;
            end
            S_ACCUM: begin
                if (accept) begin
                    if (!cont || in_last) state_d = S_HOLD;
                    else if (at_last_idx) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accept && (!cont || in_last)) state_d = S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != S_HOLD) || out_ready;
        out_valid = (state_q == S_HOLD);
    end

    generate
        if (VALUE_W >= 32) begin : g_kw_wide
            assign key_word = acc_new[31:0];
        end else begin : g_kw_narrow
            assign key_word = 32'(acc_new);
        end
    endgenerate

    always_comb begin
        shamt   = SH_W'(7) * SH_W'(idx_q);
        sh_data = VALUE_W'(in_data[6:0]) << shamt;
        if (first)                  acc_new = VALUE_W'(in_data[6:0]);
        else if (state_q == S_DRAIN) acc_new = acc_q;
        else                        acc_new = acc_q | sh_data;

        if (first)                  idx_d = IDX_W'(1);
        else if (state_q == S_ACCUM) idx_d = idx_q + IDX_W'(1);
        else                        idx_d = idx_q;

        if (first)          nbytes_new = NB_W'(1);
        else if (&nbytes_q) nbytes_new = nbytes_q;
        else                nbytes_new = nbytes_q + NB_W'(1);

        key_cur = first ? in_key : key_q;
        // Any accepted byte that lands in HOLD is the terminating byte.
        term    = accept && (state_d == S_HOLD);

        // A terminating byte with bit7 still set can only have ended on in_last.
        err_raw = 3'd0;
        if (state_q == S_DRAIN)                           err_raw = 3'd1;
        else if (cont)                                    err_raw = 3'd2;
        else if (state_q == S_ACCUM && at_last_idx && ovf) err_raw = 3'd3;

        key_bad   = (key_word[2:1] == 2'b11) || (key_word[31:3] == 29'd0);
        out_err_d = (err_raw == 3'd0 && key_cur && key_bad) ? 3'd4 : err_raw;

        if (key_cur) begin
            out_field_d = key_word[31:3];
            out_wire_d  = key_word[2:0];
        end else begin
            out_field_d = 29'd0;
            out_wire_d  = 3'd0;
        end
        if (zz_cur && !key_cur) out_value_d = {VALUE_W{acc_new[0]}} ^ (acc_new >> 1);
        else                    out_value_d = acc_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            idx_q        <= '0;
            nbytes_q     <= '0;
            key_q        <= 1'b0;
            out_value_q  <= '0;
            out_field_q  <= '0;
            out_wire_q   <= '0;
            out_nbytes_q <= '0;
            out_err_q    <= '0;
        end else begin
            if (accept) begin
                acc_q    <= acc_new;
                idx_q    <= idx_d;
                nbytes_q <= nbytes_new;
                key_q    <= key_cur;
            end
            if (term) begin
                out_value_q  <= out_value_d;
                out_field_q  <= out_field_d;
                out_wire_q   <= out_wire_d;
                out_nbytes_q <= nbytes_new;
                out_err_q    <= out_err_d;
            end
        end
    end

    assign out_value  = out_value_q;
    assign out_field  = out_field_q;
    assign out_wire   = out_wire_q;
    assign out_nbytes = out_nbytes_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_pb_varint_stream_decoder.sv
// Randomised and directed bench for pb_varint_stream_decoder (default parameters).
module tb_pb_varint_stream_decoder;

    localparam int VALUE_W   = 64;
    localparam int MAX_BYTES = 10;
    localparam int NB_W      = 4;
    localparam int NRAND     = 300;

    typedef logic [8:0] bq_t[$];
    typedef struct packed {
        logic [63:0] value;
        logic [28:0] field;
        logic [2:0]  wtype;
        logic [3:0]  nb;
        logic [2:0]  err;
    } res_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_data = 8'h00;
    logic               in_last = 1'b0;
    logic               in_key = 1'b0;
    logic               in_zigzag = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [VALUE_W-1:0] out_value;
    logic [28:0]        out_field;
    logic [2:0]         out_wire;
    logic [NB_W-1:0]    out_nbytes;
    logic [2:0]         out_err;

    int   compared = 0;
    int   mismatched = 0;
    int   stall_cnt = 0;
    logic rand_rdy = 1'b0;
    res_t obs_q[$];
    bq_t  case_q;
    logic case_key;
    res_t case_exp;

    pb_varint_stream_decoder #(.VALUE_W(VALUE_W), .MAX_BYTES(MAX_BYTES), .NB_W(NB_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_key(in_key),
`ifdef PB_VARINT_ZIGZAG_EN
        .in_zigzag(in_zigzag),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_field(out_field), .out_wire(out_wire), .out_nbytes(out_nbytes),
        .out_err(out_err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom % 3) != 0;
    end

    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            obs_q.push_back({out_value, out_field, out_wire, out_nbytes, out_err});

    // Reference: value is the arithmetic sum of the payload groups that fit,
    // errors follow from where and why the varint ended.
    function automatic res_t model(input bq_t q, input logic key, input logic zz);
        res_t        r;
        logic [127:0] full;
        logic [63:0] v;
        logic        zz_eff;
        int          t;
        r = '0;
        t = 0;
        while (t < q.size() - 1 && q[t][7] && !q[t][8]) t++;
        full = '0;
        for (int i = 0; i <= t && i < MAX_BYTES; i++)
            full = full + (128'(q[i][6:0]) << (7 * i));
        v = full[63:0];
        if (t >= MAX_BYTES)       r.err = 3'd1;
        else if (q[t][7])         r.err = 3'd2;
        else if (full[127:64] != 0) r.err = 3'd3;
        else                      r.err = 3'd0;
`ifdef PB_VARINT_ZIGZAG_EN
        zz_eff = zz;
`else
        zz_eff = 1'b0 & zz;
`endif
        if (key) begin
            r.field = v[31:3];
            r.wtype = v[2:0];
            if (r.err == 3'd0 && (r.wtype >= 3'd6 || r.field == 29'd0)) r.err = 3'd4;
            r.value = v;
        end else begin
            r.value = (zz_eff && v[0]) ? ~(v >> 1) : (zz_eff ? (v >> 1) : v);
        end
        r.nb = (t + 1 > 15) ? 4'd15 : 4'(t + 1);
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last, input logic key, input logic zz);
        int w = 0;
        in_valid = 1'b1; in_data = d; in_last = last; in_key = key; in_zigzag = zz;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
            stall_cnt++;
        end
        if (!in_ready) begin
            mismatched++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_varint(input bq_t q, input logic key, input logic zz);
        foreach (q[i]) send_byte(q[i][7:0], q[i][8], key, zz);
    endtask

    task automatic wait_obs(input int n, input string nm);
        int w = 0;
        while (obs_q.size() < n && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        compared++;
        if (obs_q.size() < n) begin
            mismatched++;
            $display("FAIL %s_result_timeout: got %0d results, required %0d", nm, obs_q.size(), n);
        end
    endtask

    task automatic build_case(input int c);
        case_q.delete();
        case_key = 1'b0;
        case_exp = '0;
        case (c)
            0: begin case_q.push_back(9'h096); case_q.push_back(9'h001);
                     case_exp.value = 64'd150; case_exp.nb = 4'd2; end
            1: begin case_q.push_back(9'h008); case_key = 1'b1;
                     case_exp.value = 64'd8; case_exp.field = 29'd1; case_exp.nb = 4'd1; end
            2: begin case_q.push_back(9'h00F); case_key = 1'b1;
                     case_exp.value = 64'd15; case_exp.field = 29'd1; case_exp.wtype = 3'd7;
                     case_exp.nb = 4'd1; case_exp.err = 3'd4; end
            3: begin repeat (9) case_q.push_back(9'h0FF); case_q.push_back(9'h001);
                     case_exp.value = 64'hFFFF_FFFF_FFFF_FFFF; case_exp.nb = 4'd10; end
            4: begin repeat (9) case_q.push_back(9'h0FF); case_q.push_back(9'h002);
                     case_exp.value = 64'h7FFF_FFFF_FFFF_FFFF; case_exp.nb = 4'd10; case_exp.err = 3'd3; end
            5: begin repeat (11) case_q.push_back(9'h080); case_q.push_back(9'h000);
                     case_exp.nb = 4'd12; case_exp.err = 3'd1; end
            6: begin case_q.push_back(9'h005); case_exp.value = 64'd5; case_exp.nb = 4'd1; end
            7: begin case_q.push_back(9'h180); case_exp.nb = 4'd1; case_exp.err = 3'd2; end
            8: begin repeat (20) case_q.push_back(9'h080); case_q.push_back(9'h000);
                     case_exp.nb = 4'd15; case_exp.err = 3'd1; end
            9: begin case_q.push_back(9'h002); case_key = 1'b1;
                     case_exp.value = 64'd2; case_exp.wtype = 3'd2; case_exp.nb = 4'd1; case_exp.err = 3'd4; end
            default: begin case_q.push_back(9'h000); end
        endcase
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared += 6;
        if (out_valid !== 1'b0)  begin mismatched++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        if (out_value !== '0)    begin mismatched++; $display("FAIL reset_out_value: got %h required 0", out_value); end
        if ({out_field, out_wire} !== '0) begin mismatched++; $display("FAIL reset_field_wire: got %h/%h required 0/0", out_field, out_wire); end
        if (out_nbytes !== '0)   begin mismatched++; $display("FAIL reset_out_nbytes: got %0d required 0", out_nbytes); end
        if (out_err !== 3'd0)    begin mismatched++; $display("FAIL reset_out_err: got %0d required 0", out_err); end
        if (in_ready !== 1'b1)   begin mismatched++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        @(posedge clk);
        #1;
        $display("test_reset: done");
    endtask

    task automatic test_directed();
        res_t got;
        for (int c = 0; c < 10; c++) begin
            obs_q.delete();
            build_case(c);
            send_varint(case_q, case_key, 1'b0);
            wait_obs(1, "directed");
            if (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                compared += 5;
                if (got.value !== case_exp.value) begin mismatched++; $display("FAIL directed%0d_value: got %h required %h", c, got.value, case_exp.value); end
                if (got.field !== case_exp.field) begin mismatched++; $display("FAIL directed%0d_field: got %0d required %0d", c, got.field, case_exp.field); end
                if (got.wtype !== case_exp.wtype) begin mismatched++; $display("FAIL directed%0d_wire: got %0d required %0d", c, got.wtype, case_exp.wtype); end
                if (got.nb !== case_exp.nb)       begin mismatched++; $display("FAIL directed%0d_nbytes: got %0d required %0d", c, got.nb, case_exp.nb); end
                if (got.err !== case_exp.err)     begin mismatched++; $display("FAIL directed%0d_err: got %0d required %0d", c, got.err, case_exp.err); end
                $display("directed case %0d: value=%h nbytes=%0d err=%0d", c, got.value, got.nb, got.err);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t got;
        obs_q.delete();
        out_ready = 1'b0;
        fork
            begin
                send_byte(8'h01, 1'b0, 1'b0, 1'b0);
                send_byte(8'h02, 1'b0, 1'b0, 1'b0);
                send_byte(8'h03, 1'b0, 1'b0, 1'b0);
            end
            begin
                int w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin @(negedge clk); w++; end
                for (int k = 0; k < 3; k++) begin
                    compared++;
                    if (out_valid !== 1'b1 || out_value !== 64'd1 || out_nbytes !== 4'd1 || in_ready !== 1'b0) begin
                        mismatched++;
                        $display("FAIL hold_stable%0d: valid=%0b value=%h nbytes=%0d in_ready=%0b required 1/1/1/0",
                                 k, out_valid, out_value, out_nbytes, in_ready);
                    end
                    @(posedge clk);
                    #1;
                    if (k < 2) @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(3, "backpressure");
        for (int k = 0; k < 3; k++) begin
            if (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                compared++;
                if (got.value !== 64'(k + 1)) begin mismatched++; $display("FAIL backpressure_order%0d: got %h required %0d", k, got.value, k + 1); end
                $display("backpressure result %0d: value=%h", k, got.value);
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t got;
        obs_q.delete();
        out_ready = 1'b1;
        send_byte(8'h80, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_mid_valid: got %0b required 0", out_valid); end
        @(posedge clk);
        #1;
        send_byte(8'h05, 1'b0, 1'b0, 1'b0);
        wait_obs(1, "reset_mid");
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (obs_q.size() != 1) begin mismatched++; $display("FAIL reset_mid_count: got %0d results required 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            compared++;
            if (got.value !== 64'd5 || got.nb !== 4'd1) begin
                mismatched++;
                $display("FAIL reset_mid_value: got %h/%0d required 5/1", got.value, got.nb);
            end
            $display("reset_mid result: value=%h nbytes=%0d", got.value, got.nb);
        end
    endtask

    task automatic test_back_to_back();
        res_t exp_q[$];
        res_t got, e;
        bq_t  q;
        logic key;
        obs_q.delete();
        out_ready = 1'b1;
        stall_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            q.delete();
            q.push_back({2'b00, 7'($urandom)});
            key = 1'($urandom);
            exp_q.push_back(model(q, key, 1'b0));
            send_varint(q, key, 1'b0);
        end
        wait_obs(16, "back_to_back");
        compared++;
        if (stall_cnt != 0) begin mismatched++; $display("FAIL back_to_back_stalls: got %0d stall cycles required 0", stall_cnt); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            e = exp_q.pop_front();
            compared++;
            if (got !== e) begin mismatched++; $display("FAIL back_to_back_result: got %h required %h", got, e); end
            $display("back_to_back: value=%h err=%0d", got.value, got.err);
        end
    endtask

    task automatic test_random();
        res_t exp_q[$];
        res_t got, e;
        bq_t  q;
        logic [8:0] b;
        logic key, zz;
        int len;
        obs_q.delete();
        rand_rdy = 1'b1;
        for (int n = 0; n < NRAND; n++) begin
            q.delete();
            len = $urandom_range(1, 13);
            for (int i = 0; i < len; i++) begin
                b[6:0] = (($urandom % 4) == 0) ? 7'h7F : 7'($urandom);
                b[7] = (i < len - 1);
                b[8] = (($urandom % 10) == 0);
                q.push_back(b);
                if (b[8]) break;
            end
            key = (($urandom % 3) == 0);
            zz  = 1'($urandom);
            exp_q.push_back(model(q, key, zz));
            send_varint(q, key, zz);
        end
        wait_obs(NRAND, "random");
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < NRAND; n++) begin
            if (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                e = exp_q.pop_front();
                compared++;
                if (got !== e) begin
                    mismatched++;
                    $display("FAIL random%0d: got value=%h field=%0d wire=%0d nb=%0d err=%0d required value=%h field=%0d wire=%0d nb=%0d err=%0d",
                             n, got.value, got.field, got.wtype, got.nb, got.err, e.value, e.field, e.wtype, e.nb, e.err);
                end
                $display("random %0d: value=%h nb=%0d err=%0d", n, got.value, got.nb, got.err);
            end
        end
    endtask

`ifdef PB_VARINT_ZIGZAG_EN
    task automatic test_zigzag();
        res_t got;
        obs_q.delete();
        out_ready = 1'b1;
        send_byte(8'h03, 1'b0, 1'b0, 1'b1);
        send_byte(8'h04, 1'b0, 1'b0, 1'b1);
        send_byte(8'h03, 1'b0, 1'b1, 1'b1);
        wait_obs(3, "zigzag");
        if (obs_q.size() >= 3) begin
            compared += 3;
            got = obs_q.pop_front();
            if (got.value !== 64'hFFFF_FFFF_FFFF_FFFE) begin mismatched++; $display("FAIL zigzag_neg: got %h required -2", got.value); end
            got = obs_q.pop_front();
            if (got.value !== 64'd2) begin mismatched++; $display("FAIL zigzag_pos: got %h required 2", got.value); end
            got = obs_q.pop_front();
            if (got.value !== 64'd3) begin mismatched++; $display("FAIL zigzag_key_raw: got %h required 3", got.value); end
            $display("zigzag: checked 3 results");
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef PB_VARINT_ZIGZAG_EN
        test_zigzag();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
